// File: rtl/wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue -- writeback queue between MEM and the register file.
//
// Retiring instructions that write a non-zero register are buffered in a
// small FIFO and drained to the register file write port whenever it is
// available. Jump beats raise a registered one-cycle redirect pulse. The
// execute stage may look up the most recent pending value for a register.
//
// Ports:
//   clk, n_rst                  clock, synchronous active-low reset
//   in_valid / in_ready         MEM beat handshake
//   in_regwrite, in_jal         beat writes a register / beat is a jump
//   in_regD, in_regdata         destination register and write value
//   in_target                   jump target
//   rf_ready                    register file write port free this cycle
//   wen, reg_num, write_data    register file write port (queue head)
//   jal_flush, j_target         one-cycle redirect pulse to the hazard unit
//   fwd_addr, fwd_hit, fwd_data forwarding lookup
//   count                       current queue occupancy
//
// Handshake: a beat transfers on any rising edge where in_valid && in_ready.
// in_ready depends only on the registered occupancy, never on in_valid or on a
// same-cycle pop. The write port pops on any edge where wen && rf_ready; while
// rf_ready is low the head (wen, reg_num, write_data) is held stable.
// ---------------------------------------------------------------------------
module wb_queue #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_regwrite,
    input  logic                       in_jal,
    input  logic [RADDR-1:0]           in_regD,
    input  logic [XLEN-1:0]            in_regdata,
    input  logic [XLEN-1:0]            in_target,
    input  logic                       rf_ready,
    output logic                       wen,
    output logic [RADDR-1:0]           reg_num,
    output logic [XLEN-1:0]            write_data,
    output logic                       jal_flush,
    output logic [XLEN-1:0]            j_target,
    input  logic [RADDR-1:0]           fwd_addr,
    output logic                       fwd_hit,
    output logic [XLEN-1:0]            fwd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [RADDR-1:0] reg_q  [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             jal_flush_q, jal_flush_d;
    logic [XLEN-1:0]  j_target_q, j_target_d;

    logic accept;
    logic enq;
    logic pop;

    assign in_ready = (count_q < CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    // Writes to x0 and non-writing beats are consumed without an entry.
    assign enq      = accept && in_regwrite && (in_regD != '0);
    assign pop      = (count_q != '0) && rf_ready;

    assign wen        = (count_q != '0);
    assign reg_num    = wen ? reg_q[rd_ptr_q]  : '0;
    assign write_data = wen ? data_q[rd_ptr_q] : '0;
    assign count      = count_q;
    assign jal_flush  = jal_flush_q;
    assign j_target   = j_target_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        jal_flush_d = 1'b0;
        j_target_d  = '0;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (accept && in_jal) begin
            jal_flush_d = 1'b1;
            j_target_d  = in_target;
        end
    end

    // Forwarding: walk from oldest to youngest so the youngest match wins,
    // then let a same-cycle enqueue override everything. A head being popped
    // this cycle is still counted as live.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        if (fwd_addr != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PW'(i);
                if ((CW'(i) < count_q) && (reg_q[idx] == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[idx];
                end
            end
            if (enq && (in_regD == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = in_regdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            jal_flush_q <= 1'b0;
            j_target_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            jal_flush_q <= jal_flush_d;
            j_target_q  <= j_target_d;
        end
    end

    // Entry storage needs no reset: contents are only observed below count.
    always_ff @(posedge clk) begin
        if (n_rst && enq) begin
            reg_q[wr_ptr_q]  <= in_regD;
            data_q[wr_ptr_q] <= in_regdata;
        end
    end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter XLEN, default 32: data and target width.
REQ-002 Parameter RADDR, default 5: register-index width; index 0 is the hardwired zero register.
REQ-003 Parameter DEPTH, default 4: pending-write queue entries; power of two, >=2.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 n_rst  in  1  synchronous, active-low reset.
REQ-006 in_valid  in  1  MEM stage presents a retiring instruction.
REQ-007 in_ready  out  1  wb_queue accepts the beat this cycle.
REQ-008 in_regwrite, in_jal  in  1 each  instruction writes a register / is a jump.
REQ-009 in_regD  in  RADDR  destination register.
REQ-010 in_regdata, in_target  in  XLEN each  write value / jump target.
REQ-011 rf_ready  in  1  register file write port available this cycle.
REQ-012 wen  out  1; reg_num  out  RADDR; write_data  out  XLEN: register file write port.
REQ-013 jal_flush  out  1; j_target  out  XLEN: hazard-unit redirect.
REQ-014 fwd_addr  in  RADDR; fwd_hit  out  1; fwd_data  out  XLEN: execute-stage forwarding lookup.
REQ-015 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Accept = in_valid && in_ready; in_ready = (count < DEPTH), combinational, independent of same-cycle pop.
REQ-017 Enqueue on accept when in_regwrite=1 and in_regD!=0; in_regwrite=0 or in_regD=0 beats are accepted and discarded (no entry).
REQ-018 Queue is FIFO; write/read pointers RADDR-independent, log2(DEPTH) bits, wrap modulo DEPTH.
REQ-019 wen = (count != 0); reg_num/write_data = head entry; when count=0 reg_num=0, write_data=0.
REQ-020 Pop when wen && rf_ready; wen held with stable head while rf_ready=0.
REQ-021 Simultaneous enqueue and pop: count unchanged, both pointers advance.
REQ-022 Write latency: entry accepted in cycle N appears on the port no earlier than cycle N+1.
REQ-023 On accepted beat with in_jal=1: jal_flush=1 and j_target=in_target in cycle N+1 only (registered one-cycle pulse); otherwise jal_flush=0, j_target=0.
REQ-024 Back-to-back accepted jal beats produce back-to-back pulses, each with its own target.
REQ-025 A jal with in_regwrite=1 and in_regD!=0 also enqueues its link value per REQ-017.
REQ-026 Forwarding (combinational): fwd_addr=0 -> fwd_hit=0, fwd_data=0.
REQ-027 Priority: accepted beat this cycle enqueuing fwd_addr, then youngest matching queue entry, then oldest; result drives fwd_data, fwd_hit=1.
REQ-028 No match -> fwd_hit=0, fwd_data=0.
REQ-029 Entry being popped this cycle still participates in forwarding.

Reset
REQ-030 While n_rst=0 at a clock edge: pointers=0, count=0, jal_flush=0, j_target=0; wen=0, reg_num=0, write_data=0 follow combinationally.
REQ-031 Reset mid-operation discards all pending entries and any pending jal pulse; in_ready=1 the cycle after reset deasserts.
REQ-032 Beats presented while n_rst=0 are not enqueued and generate no pulse.

Verification
REQ-033 Single write: accept {regD=5, data=0xDEADBEEF}, rf_ready=1 -> next cycle wen=1, reg_num=5, write_data=0xDEADBEEF, count=1; following cycle count=0, wen=0.
REQ-034 Backpressure: rf_ready=0, accept 4 writes to x1..x4 -> count=4, in_ready=0; a 5th beat is not accepted; rf_ready=1 -> writes x1..x4 in order over 4 cycles.
REQ-035 Full + pop: count=4, rf_ready=1, in_valid=1 -> in_ready=0 that cycle, count=3 next, beat accepted following cycle.
REQ-036 Jal: accept in_jal=1, target=0x80, regD=1, data=0x44 -> next cycle jal_flush=1, j_target=0x80 for one cycle only, x1<=0x44 written.
REQ-037 Forwarding: queue holds x7=0x11 then x7=0x22, fwd_addr=7 -> fwd_data=0x22; same-cycle accepted x7=0x33 -> fwd_data=0x33; fwd_addr=0 -> fwd_hit=0.
REQ-038 Reset with count=3 and pending jal pulse -> next cycle count=0, wen=0, jal_flush=0; writes to x0 never enqueue.
